// File: rtl/song_seq_pkg.sv
// rtl/song_seq_pkg.sv - entry format and FSM encoding for song_sequencer
package song_seq_pkg;

  localparam logic [1:0] KIND_NOTE = 2'b00;
  localparam logic [1:0] KIND_WAIT = 2'b01;
  localparam logic [1:0] KIND_END  = 2'b10;

  localparam int KIND_HI   = 15;
  localparam int KIND_LO   = 14;
  localparam int NOTE_HI   = 13;
  localparam int NOTE_LO   = 8;
  localparam int WEIGHT_HI = 7;
  localparam int WEIGHT_LO = 6;
  localparam int DUR_HI    = 5;
  localparam int DUR_LO    = 0;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    WAITING = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/slot_timer.sv
// rtl/slot_timer.sv - per-slot beat down-counter with busy flag and done pulse
module slot_timer #(
  parameter int DUR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] dur,
  input  logic             tick,
  input  logic             clear,
  output logic             busy,
  output logic             done
);

  logic [DUR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      // clear wins over load so a song switch never leaves a stale note behind
      if (clear) begin
        done  <= busy;
        busy  <= 1'b0;
        count <= '0;
      end else if (load) begin
        count <= dur;
        busy  <= 1'b1;
      end else if (tick && busy) begin
        count <= count - DUR_W'(1);
        if (count == DUR_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - walks a song ROM and hands NOTE events to free player slots
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int NUM_SLOTS = 3,
  parameter int ADDR_W    = 7,
  parameter int SONG_W    = 2,
  parameter int DUR_W     = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic                     beat,
  input  logic [SONG_W-1:0]        song_sel,
  output logic [SONG_W+ADDR_W-1:0] rom_addr,
  input  logic [15:0]              rom_data,
  output logic [5:0]               note_to_load,
  output logic [1:0]               weight,
  output logic [NUM_SLOTS-1:0]     load_new_note,
  output logic [NUM_SLOTS-1:0]     note_done,
  output logic                     song_done
);

  seq_state_t         state;
  logic [SONG_W-1:0]  song_q;
  logic [ADDR_W-1:0]  idx;
  logic [DUR_W-1:0]   wcnt;

  logic [1:0]         rom_kind;
  logic [5:0]         rom_note;
  logic [1:0]         rom_weight;
  logic [DUR_W-1:0]   rom_dur;

  logic               song_change;
  logic               step;
  logic               tick;
  logic [NUM_SLOTS-1:0] busy;
  logic [NUM_SLOTS-1:0] free_slot;
  logic [NUM_SLOTS-1:0] load_vec;
  seq_state_t         adv_state;
  logic [ADDR_W-1:0]  adv_idx;

  assign rom_kind   = rom_data[KIND_HI:KIND_LO];
  assign rom_note   = rom_data[NOTE_HI:NOTE_LO];
  assign rom_weight = rom_data[WEIGHT_HI:WEIGHT_LO];
  assign rom_dur    = DUR_W'(rom_data[DUR_HI:DUR_LO]);

  assign rom_addr    = {song_q, idx};
  assign song_change = (song_sel != song_q);
  assign step        = play && !song_change;
  assign tick        = beat && step;

  always_comb begin
    free_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_slot    = '0;
        free_slot[i] = 1'b1;
      end
    end
  end

  // free_slot is zero when every slot is busy, which drops the note
  assign load_vec = (state == DECODE && step && rom_kind == KIND_NOTE && rom_dur != '0)
                    ? free_slot : '0;

  // stepping past the last entry ends the song instead of wrapping
  always_comb begin
    adv_state = FETCH;
    adv_idx   = idx + ADDR_W'(1);
    if (idx == '1) begin
      adv_state = DRAIN;
      adv_idx   = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      song_q        <= song_sel;
      idx           <= '0;
      wcnt          <= '0;
      song_done     <= 1'b0;
      load_new_note <= '0;
      note_to_load  <= '0;
      weight        <= '0;
    end else begin
      load_new_note <= '0;
      if (song_change) begin
        state     <= FETCH;
        song_q    <= song_sel;
        idx       <= '0;
        wcnt      <= '0;
        song_done <= 1'b0;
      end else if (play) begin
        case (state)
          FETCH: state <= DECODE;
          DECODE: begin
            if (load_vec != '0) begin
              load_new_note <= load_vec;
              note_to_load  <= rom_note;
              weight        <= rom_weight;
            end
            if (rom_kind == KIND_NOTE) begin
              state <= adv_state;
              idx   <= adv_idx;
            end else if (rom_kind == KIND_WAIT) begin
              if (rom_dur != '0) begin
                wcnt  <= rom_dur;
                state <= WAITING;
              end else begin
                state <= adv_state;
                idx   <= adv_idx;
              end
            end else begin
              state <= DRAIN;
            end
          end
          WAITING: begin
            if (beat) begin
              if (wcnt == DUR_W'(1)) begin
                state <= adv_state;
                idx   <= adv_idx;
              end else begin
                wcnt <= wcnt - DUR_W'(1);
              end
            end
          end
          DRAIN: begin
            if (busy == '0) begin
              state     <= DONE;
              song_done <= 1'b1;
            end
          end
          DONE: state <= DONE;
          default: state <= FETCH;
        endcase
      end
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    slot_timer #(.DUR_W(DUR_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load_vec[s]),
      .dur   (rom_dur),
      .tick  (tick),
      .clear (song_change),
      .busy  (busy[s]),
      .done  (note_done[s])
    );
  end

endmodule
